// File: rtl/piso_serializer_pkg.sv
// Shared types and helpers for the PISO serializer: FSM state encoding and counter sizing.
package piso_serializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Counter needs at least one bit even for single-bit words.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// Modulo-WIDTH bit counter with synchronous clear, enable and a terminal-count flag.
import piso_serializer_pkg::*;

module bit_counter #(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] count;

    // Clear wins over enable; an enable at terminal count wraps to zero, never past WIDTH-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= (count == LAST) ? '0 : count + CNT_W'(1);
        end
    end

    assign tc = (count == LAST);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: accepts a WIDTH-bit word via valid/ready and shifts it out one bit per clock.
import piso_serializer_pkg::*;

module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_valid,
    input  logic [WIDTH-1:0] din,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic             busy
);

    state_t           state, next_state;
    logic [WIDTH-1:0] shreg, next_shreg;
    logic             tc;
    logic             cnt_clr, cnt_en;
    logic             accept;

    bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .tc  (tc)
    );

    // A new word may enter while idle or during the final bit, so words stream gap-free.
    assign din_ready = !rst && ((state == ST_IDLE) || tc);
    assign accept    = din_valid && din_ready;

    always_comb begin
        next_state = state;
        next_shreg = shreg;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    next_shreg = din;
                    next_state = ST_SHIFT;
                    cnt_clr    = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (!tc) begin
                    next_shreg = (MSB_FIRST != 0) ? (shreg << 1) : (shreg >> 1);
                    cnt_en     = 1'b1;
                end else if (accept) begin
                    next_shreg = din;
                    cnt_clr    = 1'b1;
                end else begin
                    next_shreg = '0;
                    next_state = ST_IDLE;
                    cnt_clr    = 1'b1;
                end
            end
            default: begin
                next_shreg = '0;
                next_state = ST_IDLE;
                cnt_clr    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            shreg <= '0;
        end else begin
            state <= next_state;
            shreg <= next_shreg;
        end
    end

    // The shift register is zeroed whenever the FSM idles, so sout is already 0 outside SHIFT.
    assign sout       = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];
    assign sout_valid = (state == ST_SHIFT);
    assign sout_last  = sout_valid && tc;
    assign busy       = sout_valid;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed self-checking bench for piso_serializer: MSB-first table plus LSB-first and WIDTH=1 sequences.
module tb_piso_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0, dv0, rdy0, so0, sv0, sl0, busy0;
    logic [3:0] din0;
    logic       rst1, dv1, rdy1, so1, sv1, sl1, busy1;
    logic [3:0] din1;
    logic       rst2, dv2, rdy2, so2, sv2, sl2, busy2;
    logic [0:0] din2;

    piso_serializer #(.WIDTH(4), .MSB_FIRST(1)) dut_msb (
        .clk(clk), .rst(rst0), .din_valid(dv0), .din(din0), .din_ready(rdy0),
        .sout(so0), .sout_valid(sv0), .sout_last(sl0), .busy(busy0)
    );

    piso_serializer #(.WIDTH(4), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .rst(rst1), .din_valid(dv1), .din(din1), .din_ready(rdy1),
        .sout(so1), .sout_valid(sv1), .sout_last(sl1), .busy(busy1)
    );

    piso_serializer #(.WIDTH(1), .MSB_FIRST(1)) dut_w1 (
        .clk(clk), .rst(rst2), .din_valid(dv2), .din(din2), .din_ready(rdy2),
        .sout(so2), .sout_valid(sv2), .sout_last(sl2), .busy(busy2)
    );

    typedef struct {
        logic       rst;
        logic       dv;
        logic [3:0] din;
        logic       rdy;
        logic       so;
        logic       sv;
        logic       sl;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    task automatic addVec(input logic r, input logic dv, input logic [3:0] d,
                          input logic rdy, input logic so, input logic sv, input logic sl);
        vec_t v;
        v.rst = r; v.dv = dv; v.din = d; v.rdy = rdy; v.so = so; v.sv = sv; v.sl = sl;
        vecs.push_back(v);
    endtask

    task automatic checkOutput(input string name, input int idx, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s[%0d] actual=%b required=%b", name, idx, act, exp);
        end
    endtask

    task automatic checkLane(input string tag, input int idx,
                             input logic rdy, input logic so, input logic sv, input logic sl, input logic bz,
                             input logic er, input logic es, input logic ev, input logic el);
        checkOutput({tag, ".din_ready"},  idx, rdy, er);
        checkOutput({tag, ".sout"},       idx, so,  es);
        checkOutput({tag, ".sout_valid"}, idx, sv,  ev);
        checkOutput({tag, ".sout_last"},  idx, sl,  el);
        checkOutput({tag, ".busy"},       idx, bz,  ev);
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later, away from the rising edge.
    task automatic applyStimulus(input vec_t v, input int idx);
        @(negedge clk);
        rst0 = v.rst;
        dv0  = v.dv;
        din0 = v.din;
        #1;
        checkLane("msb", idx, rdy0, so0, sv0, sl0, busy0, v.rdy, v.so, v.sv, v.sl);
    endtask

    initial begin
        logic exp_lsb [4];
        logic w1_in   [3];

        rst0 = 1'b1; dv0 = 1'b1; din0 = 4'hF;
        rst1 = 1'b1; dv1 = 1'b0; din1 = 4'h0;
        rst2 = 1'b1; dv2 = 1'b0; din2 = 1'b0;

        // rst, dv, din, | ready, sout, valid, last
        // reset held three cycles with din_valid asserted
        addVec(1, 1, 4'hF,  0, 0, 0, 0);
        addVec(1, 1, 4'hF,  0, 0, 0, 0);
        addVec(1, 1, 4'hF,  0, 0, 0, 0);
        // single word 1010
        addVec(0, 1, 4'b1010, 1, 0, 0, 0);
        addVec(0, 0, 4'h0,  0, 1, 1, 0);
        addVec(0, 0, 4'h0,  0, 0, 1, 0);
        addVec(0, 0, 4'h0,  0, 1, 1, 0);
        addVec(0, 0, 4'h0,  1, 0, 1, 1);
        addVec(0, 0, 4'h0,  1, 0, 0, 0);
        // back-to-back 1111 then 1100
        addVec(0, 1, 4'b1111, 1, 0, 0, 0);
        addVec(0, 1, 4'b1100, 0, 1, 1, 0);
        addVec(0, 1, 4'b1100, 0, 1, 1, 0);
        addVec(0, 1, 4'b1100, 0, 1, 1, 0);
        addVec(0, 1, 4'b1100, 1, 1, 1, 1);
        addVec(0, 0, 4'h0,  0, 1, 1, 0);
        addVec(0, 0, 4'h0,  0, 1, 1, 0);
        addVec(0, 0, 4'h0,  0, 0, 1, 0);
        addVec(0, 0, 4'h0,  1, 0, 1, 1);
        addVec(0, 0, 4'h0,  1, 0, 0, 0);
        // 0110 offered during bit 2 of 1010, held until ready
        addVec(0, 1, 4'b1010, 1, 0, 0, 0);
        addVec(0, 0, 4'h0,  0, 1, 1, 0);
        addVec(0, 1, 4'b0110, 0, 0, 1, 0);
        addVec(0, 1, 4'b0110, 0, 1, 1, 0);
        addVec(0, 1, 4'b0110, 1, 0, 1, 1);
        addVec(0, 0, 4'h0,  0, 0, 1, 0);
        addVec(0, 0, 4'h0,  0, 1, 1, 0);
        addVec(0, 0, 4'h0,  0, 1, 1, 0);
        addVec(0, 0, 4'h0,  1, 0, 1, 1);
        addVec(0, 0, 4'h0,  1, 0, 0, 0);
        // reset pulsed after two bits of 1010, then 0110
        addVec(0, 1, 4'b1010, 1, 0, 0, 0);
        addVec(0, 0, 4'h0,  0, 1, 1, 0);
        addVec(0, 0, 4'h0,  0, 0, 1, 0);
        addVec(1, 0, 4'h0,  0, 0, 0, 0);
        addVec(0, 1, 4'b0110, 1, 0, 0, 0);
        addVec(0, 0, 4'h0,  0, 0, 1, 0);
        addVec(0, 0, 4'h0,  0, 1, 1, 0);
        addVec(0, 0, 4'h0,  0, 1, 1, 0);
        addVec(0, 0, 4'h0,  1, 0, 1, 1);
        addVec(0, 0, 4'h0,  1, 0, 0, 0);

        foreach (vecs[i]) applyStimulus(vecs[i], i);

        // LSB-first: 1010 leaves as 0,1,0,1
        exp_lsb = '{1'b0, 1'b1, 1'b0, 1'b1};
        @(negedge clk);
        rst1 = 1'b0; dv1 = 1'b1; din1 = 4'b1010;
        #1 checkLane("lsb", 0, rdy1, so1, sv1, sl1, busy1, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            dv1 = 1'b0; din1 = 4'h0;
            #1 checkLane("lsb", i + 1, rdy1, so1, sv1, sl1, busy1, (i == 3), exp_lsb[i], 1'b1, (i == 3));
        end
        @(negedge clk);
        #1 checkLane("lsb", 5, rdy1, so1, sv1, sl1, busy1, 1, 0, 0, 0);

        // WIDTH=1 stream 1,0,1 with din_valid held: every bit is a last bit, ready never drops
        w1_in = '{1'b1, 1'b0, 1'b1};
        @(negedge clk);
        rst2 = 1'b0; dv2 = 1'b1; din2 = w1_in[0];
        #1 checkLane("w1", 0, rdy2, so2, sv2, sl2, busy2, 1, 0, 0, 0);
        for (int i = 1; i < 3; i++) begin
            @(negedge clk);
            din2 = w1_in[i];
            #1 checkLane("w1", i, rdy2, so2, sv2, sl2, busy2, 1, w1_in[i-1], 1, 1);
        end
        @(negedge clk);
        dv2 = 1'b0; din2 = 1'b0;
        #1 checkLane("w1", 3, rdy2, so2, sv2, sl2, busy2, 1, w1_in[2], 1, 1);
        @(negedge clk);
        #1 checkLane("w1", 4, rdy2, so2, sv2, sl2, busy2, 1, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
